// File: rtl/acc_load_unit.sv
// acc_load_unit: registered accumulator load from memory/immediate/ALU/hold with memory-wait timeout
// Ports: clk, rst_n (async active-low); SelA source select, WrAcc load request;
// from_memory + mem_valid, from_signal (immediate), from_alu data sources; err_clr clears timeout_err;
// acc with zero/neg flags, busy while waiting for memory, load_done pulse, sticky timeout_err.
module acc_load_unit #(
  parameter int DATA_LENGTH    = 16,
  parameter int IMM_LENGTH     = 11,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             SelA,
  input  logic                   WrAcc,
  input  logic [DATA_LENGTH-1:0] from_memory,
  input  logic                   mem_valid,
  input  logic [IMM_LENGTH-1:0]  from_signal,
  input  logic [DATA_LENGTH-1:0] from_alu,
  input  logic                   err_clr,
  output logic [DATA_LENGTH-1:0] acc,
  output logic                   zero,
  output logic                   neg,
  output logic                   busy,
  output logic                   load_done,
  output logic                   timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_LENGTH-1:0] acc_n, imm;
  logic done_n, to_n;
  assign imm = DATA_LENGTH'($signed(from_signal));
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    done_n  = 1'b0;
    to_n    = 1'b0;
    if (state == IDLE) begin
      if (WrAcc) begin
        if (SelA == 2'b00 && !mem_valid) begin
          state_n = WAIT_MEM;
          cnt_n   = CW'(1);
        end else begin
          done_n = 1'b1;
          acc_n  = SelA == 2'b00 ? from_memory : SelA == 2'b01 ? imm : SelA == 2'b10 ? from_alu : acc;
        end
      end
    end else if (mem_valid) begin
      // data arriving on the last counted cycle still wins over the timeout
      acc_n   = from_memory;
      state_n = IDLE;
      cnt_n   = '0;
      done_n  = 1'b1;
    end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
      state_n = IDLE;
      cnt_n   = '0;
      to_n    = 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  // flags are computed from the next acc so they always match acc in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      zero        <= 1'b1;
      neg         <= 1'b0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      zero        <= acc_n == '0;
      neg         <= acc_n[DATA_LENGTH-1];
      busy        <= state_n == WAIT_MEM;
      load_done   <= done_n;
      timeout_err <= to_n | (timeout_err & ~err_clr);
    end
  end
endmodule

// File: doc/acc_load_unit.md
Name: acc_load_unit

Overview:
- Registered accumulator-load unit for the BIP datapath; successor to the combinational accumulator source select.
- Selects the accumulator source from four sources:
  - data memory
  - sign-extended instruction immediate
  - ALU result
  - hold
- Adds a memory-wait handshake with timeout, zero/negative flags and a load-complete pulse.
- Sits between the control unit (SelA, WrAcc), data memory and ALU; drives the ALU A operand and the store-data path.

Parameters:
- DATA_LENGTH, 16, width of accumulator, memory data and ALU result.
- IMM_LENGTH, 11, width of the instruction immediate field; must be ≤ DATA_LENGTH.
- TIMEOUT_CYCLES, 8, maximum cycles to wait for mem_valid before aborting a memory load; ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SelA  in  2  source select: 00 MEMORY, 01 SIGNAL (immediate), 10 ALU, 11 HOLD.
- WrAcc  in  1  load request, sampled each rising edge.
- from_memory  in  DATA_LENGTH  memory read data.
- mem_valid  in  1  from_memory valid this cycle.
- from_signal  in  IMM_LENGTH  instruction immediate, two's complement.
- from_alu  in  DATA_LENGTH  ALU result.
- err_clr  in  1  clears the sticky timeout error.
- acc  out  DATA_LENGTH  accumulator value.
- zero  out  1  acc == 0.
- neg  out  1  acc[DATA_LENGTH-1].
- busy  out  1  waiting for memory data.
- load_done  out  1  one-cycle pulse after any completed request.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc = 0, zero = 1, neg = 0, busy = 0, load_done = 0, timeout_err = 0.
  - State returns to IDLE; wait counter = 0.
  - Asserting reset mid-wait aborts the load with no acc update.
- Immediate: sign-extended from IMM_LENGTH to DATA_LENGTH by replicating from_signal[IMM_LENGTH-1]. Example: 11'h7FF → 16'hFFFF; 11'h3FF → 16'h03FF.
- zero and neg are registered with acc and always consistent with the acc value of the same cycle.
- State IDLE (busy = 0):
  - WrAcc = 0: nothing changes.
  - WrAcc = 1, SelA = 01: acc loads the sign-extended immediate at this edge; load_done = 1 next cycle.
  - WrAcc = 1, SelA = 10: acc loads from_alu at this edge; load_done = 1 next cycle.
  - WrAcc = 1, SelA = 11: acc is unchanged; load_done still pulses.
  - WrAcc = 1, SelA = 00, mem_valid = 1: acc loads from_memory at this edge; zero wait cycles.
  - WrAcc = 1, SelA = 00, mem_valid = 0: go to WAIT_MEM; busy = 1 from the next cycle; counter = 1.
- State WAIT_MEM (busy = 1):
  - SelA, WrAcc and from_signal are ignored; the request is already committed to MEMORY.
  - mem_valid = 1: acc loads from_memory; return to IDLE; busy = 0 and load_done = 1 next cycle.
  - mem_valid = 0 and counter == TIMEOUT_CYCLES: return to IDLE without loading acc; timeout_err = 1; load_done is not pulsed.
  - Otherwise the counter increments.
  - mem_valid arriving in the same cycle the counter reaches TIMEOUT_CYCLES: the load wins and no error is raised.
- load_done is exactly one cycle wide. Back-to-back WrAcc in IDLE produces consecutive loads and a continuously high load_done.
- timeout_err:
  - Set by a timeout; cleared only by err_clr or reset.
  - err_clr in the same cycle as a new timeout: set wins.
  - Does not block further loads.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive rst_n low mid-cycle with acc = 16'h1234 → acc = 0, zero = 1, busy = 0, timeout_err = 0 immediately, without waiting for a clock edge.
- Immediate sign extension: WrAcc = 1, SelA = 01, from_signal = 11'h400 → next cycle acc = 16'hFC00, neg = 1, load_done = 1 for one cycle. Then from_signal = 11'h000 → acc = 0, zero = 1.
- ALU and HOLD: WrAcc with SelA = 10, from_alu = 16'h00AB → acc = 16'h00AB. Then WrAcc with SelA = 11 → acc stays 16'h00AB and load_done pulses.
- Memory wait: WrAcc, SelA = 00, mem_valid = 0; raise mem_valid with from_memory = 16'h8001 three cycles later; toggle SelA during the wait → busy high for 3 cycles; acc = 16'h8001, neg = 1; exactly one load_done; SelA changes have no effect.
- Timeout: TIMEOUT_CYCLES = 8, WrAcc with SelA = 00, mem_valid held 0 → after 8 wait cycles busy = 0, timeout_err = 1, acc unchanged, no load_done. Then pulse err_clr → timeout_err = 0.
- Boundary: mem_valid asserted in the final counted wait cycle → load occurs and timeout_err stays 0. Reset asserted during WAIT_MEM → busy = 0 and acc = 0.
